// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART deframer with 2-flop synchronizer, mid-bit sampling, parity/framing/overrun status.
module uart_rx_engine #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic [KW-1:0] k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  input  logic          clr_rxrdy,
  output logic [7:0]    rx_data,
  output logic          rxrdy,
  output logic          perr,
  output logic          ferr,
  output logic          ovf
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic r_rxs_d, r_eight, r_pen, r_ohel, r_perr_n;
  logic [KW-1:0] r_k, r_btc, w_target;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic w_rxs, w_edge, w_tick, w_last;
  assign w_rxs = r_sync[1];
  assign w_edge = r_state == IDLE && r_rxs_d && !w_rxs;
  assign w_target = r_state == START ? r_k >> 1 : r_k;
  assign w_tick = r_state != IDLE && r_btc == w_target - KW'(1);
  assign w_last = r_idx == {2'b11, r_eight};
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_edge ? START : IDLE;
      START:   w_next = !w_tick ? START : (w_rxs ? IDLE : DATA);
      DATA:    w_next = !(w_tick && w_last) ? DATA : (r_pen ? PAR : STOP);
      PAR:     w_next = w_tick ? STOP : PAR;
      STOP:    w_next = w_tick ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= 2'b11;
      r_rxs_d  <= 1'b1;
      r_k      <= '0;
      r_eight  <= 1'b0;
      r_pen    <= 1'b0;
      r_ohel   <= 1'b0;
      r_btc    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_perr_n <= 1'b0;
      rx_data  <= '0;
      rxrdy    <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_rxs_d <= w_rxs;
      if (w_edge) begin
        r_k      <= k;
        r_eight  <= eight;
        r_pen    <= pen;
        r_ohel   <= ohel;
        r_btc    <= '0;
        r_idx    <= '0;
        r_shift  <= '0;
        r_perr_n <= 1'b0;
      end else if (r_state != IDLE) r_btc <= w_tick ? '0 : r_btc + KW'(1);
      if (w_tick && r_state == DATA) begin
        r_shift[r_idx] <= w_rxs;
        r_idx          <= r_idx + 3'd1;
      end
      // unused bit 7 stays 0 in 7-bit mode, so the full-width XOR is correct for both sizes
      if (w_tick && r_state == PAR) r_perr_n <= w_rxs ^ (^r_shift) ^ r_ohel;
      if (w_tick && r_state == STOP) begin
        rx_data <= r_shift;
        perr    <= r_perr_n;
        ferr    <= ~w_rxs;
        rxrdy   <= 1'b1;
        ovf     <= rxrdy & ~clr_rxrdy;
      end else if (clr_rxrdy) begin
        rxrdy <= 1'b0;
        ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: randomized frames checked every cycle against a frame-level model, plus directed literal checks.
module tb_uart_rx_engine;
  localparam int KW = 19;
  logic clk = 0, reset = 1, rx = 1, eight = 1, pen = 0, ohel = 0, clr_rxrdy = 0;
  logic [KW-1:0] k = 16;
  logic [7:0] rx_data;
  logic rxrdy, perr, ferr, ovf;
  int total = 0, bad = 0, cyc = 0;
  bit dir_clr = 0, rand_clr = 0;
  typedef struct {int m; logic [7:0] d; bit pe; bit fe;} ev_t;
  ev_t q[$];
  logic [7:0] m_d = 0;
  bit m_rdy = 0, m_pe = 0, m_fe = 0, m_ovf = 0;

  always #5 clk = ~clk;

  uart_rx_engine #(.KW(KW)) dut (
    .clk(clk), .reset(reset), .rx(rx), .k(k), .eight(eight), .pen(pen), .ohel(ohel),
    .clr_rxrdy(clr_rxrdy), .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Frame-level model: each queued frame completes at its predicted clock edge.
  initial begin : model
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        q.delete();
        m_d = 0; m_rdy = 0; m_pe = 0; m_fe = 0; m_ovf = 0;
      end else if (q.size() > 0 && q[0].m == cyc) begin
        e = q.pop_front();
        m_ovf = m_rdy && !clr_rxrdy;
        m_rdy = 1; m_d = e.d; m_pe = e.pe; m_fe = e.fe;
      end else if (clr_rxrdy) begin
        m_rdy = 0; m_ovf = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1 clr_rxrdy = dir_clr | (rand_clr && $urandom_range(0, 7) == 0);
  end

  initial forever begin
    @(negedge clk);
    chk("cycle", {rx_data, rxrdy, perr, ferr, ovf}, reset ? 12'h0 : {m_d, m_rdy, m_pe, m_fe, m_ovf});
  end

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send(input int kk, input bit e8, input bit p, input bit o, input logic [7:0] d,
                      input bit flip, input bit stopb, input bit scramble);
    logic [7:0] dm;
    bit par;
    int nb;
    ev_t e;
    dm = e8 ? d : {1'b0, d[6:0]};
    par = (^dm) ^ o ^ flip;
    nb = (e8 ? 8 : 7) + int'(p) + 1;
    k = KW'(kk); eight = e8; pen = p; ohel = o; rx = 0;
    e.m = cyc + 3 + kk / 2 + kk * nb; e.d = dm; e.pe = p & flip; e.fe = !stopb;
    q.push_back(e);
    repeat (kk) @(negedge clk);
    if (scramble) begin
      k = KW'($urandom_range(16, 200)); eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
    end
    for (int i = 0; i < (e8 ? 8 : 7); i++) begin
      rx = dm[i];
      repeat (kk) @(negedge clk);
    end
    if (p) begin
      rx = par;
      repeat (kk) @(negedge clk);
    end
    rx = stopb;
    repeat (kk) @(negedge clk);
  endtask

  task automatic pulse_clr();
    dir_clr = 1;
    @(negedge clk);
    dir_clr = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int kk;
    bit stopb;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rx_data, rxrdy, perr, ferr, ovf}, 12'h000);
    #2 reset = 0;
    @(negedge clk);
    send(16, 1, 1, 0, 8'hA5, 0, 1, 0);
    chk("frame_8E", {rx_data, rxrdy, perr, ferr, ovf}, {8'hA5, 4'b1000});
    chk("model_8E", {m_d, m_rdy, m_pe, m_fe, m_ovf}, {8'hA5, 4'b1000});
    pulse_clr();
    chk("clr_after_8E", {10'h0, rxrdy, ovf}, 12'h0);
    send(16, 0, 1, 1, 8'h41, 1, 1, 0);
    chk("parity_7O", {rx_data, rxrdy, perr, ferr, ovf}, {8'h41, 4'b1100});
    pulse_clr();
    send(16, 1, 0, 0, 8'h3C, 0, 0, 0);
    chk("framing_8N1", {rx_data, rxrdy, perr, ferr, ovf}, {8'h3C, 4'b1010});
    pulse_clr();
    repeat (80) @(negedge clk);
    chk("break_no_frame", {11'h0, rxrdy}, 12'h0);
    rx = 1;
    repeat (20) @(negedge clk);
    rx = 0;
    repeat (4) @(negedge clk);
    rx = 1;
    repeat (30) @(negedge clk);
    chk("false_start", {11'h0, rxrdy}, 12'h0);
    send(16, 1, 0, 0, 8'h55, 0, 1, 0);
    chk("after_false_start", {rx_data, rxrdy, perr, ferr, ovf}, {8'h55, 4'b1000});
    pulse_clr();
    send(16, 1, 0, 0, 8'h11, 0, 1, 0);
    send(16, 1, 0, 0, 8'h22, 0, 1, 0);
    chk("overrun", {rx_data, rxrdy, perr, ferr, ovf}, {8'h22, 4'b1001});
    pulse_clr();
    chk("overrun_clr", {rx_data, rxrdy, perr, ferr, ovf}, {8'h22, 4'b0000});
    send(16, 1, 0, 0, 8'h11, 0, 1, 0);
    fork
      send(16, 1, 0, 0, 8'h33, 0, 1, 0);
      begin
        repeat (2) @(negedge clk);
        repeat (q[0].m - 1 - cyc) @(negedge clk);
        dir_clr = 1;
        @(negedge clk);
        dir_clr = 0;
      end
    join
    chk("clr_collision", {rx_data, rxrdy, perr, ferr, ovf}, {8'h33, 4'b1000});
    b = 8'h5A;
    k = 16; eight = 1; pen = 0; rx = 0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = b[3];
    repeat (8) @(negedge clk);
    #2 reset = 1;
    #1 chk("reset_midframe", {rx_data, rxrdy, perr, ferr, ovf}, 12'h000);
    rx = 1;
    repeat (2) @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    send(16, 1, 0, 0, 8'h96, 0, 1, 0);
    chk("after_reset", {rx_data, rxrdy, perr, ferr, ovf}, {8'h96, 4'b1000});
    pulse_clr();
    rand_clr = 1;
    for (int n = 0; n < 40; n++) begin
      kk = $urandom_range(16, 33);
      stopb = $urandom_range(0, 5) != 0;
      send(kk, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 4) == 0, stopb, 1);
      if (!stopb) begin
        rx = 1;
        repeat (3) @(negedge clk);
      end else repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_clr = 0;
    repeat (50) @(negedge clk);
    chk("drain", 12'(q.size()), 12'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

UART receive engine: the deframing counterpart of the transmit-side parity/stop-bit encoder. It synchronizes the serial `rx` line, detects and validates start bits, and samples 7 or 8 data bits, an optional parity bit and one stop bit at mid-bit using a programmable bit-time count. It presents the received byte with parity-error, framing-error and overrun status to the TSI/register side through a ready flag cleared by a read strobe.

## Interface
- `KW`, default 19: width of bit-time count `k`.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high; asynchronous to `clk`.
- `k`  in  KW  bit time in `clk` cycles; legal range 16..2^KW-1.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  1 = parity bit present.
- `ohel`  in  1  0 = even parity (XOR of data bits), 1 = odd parity (XNOR).
- `clr_rxrdy`  in  1  one-cycle read strobe from the register side.
- `rx_data`  out  8  received byte, LSB first on the line; bit 7 forced 0 when `eight`=0.
- `rxrdy`  out  1  new byte available.
- `perr`  out  1  parity error for the byte in `rx_data`.
- `ferr`  out  1  framing error (stop bit sampled low) for the byte in `rx_data`.
- `ovf`  out  1  overrun: a frame completed while `rxrdy` was still set.

## Operation
- `rx` passes through a two-flop synchronizer giving `rxs`; `rxs_d` is `rxs` delayed one cycle. All decisions use `rxs`.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: on `rxs_d`=1 and `rxs`=0 (falling edge), latch `k`, `eight`, `pen`, `ohel`, clear bit-time counter `btc` and bit index, and go to START. These latched copies govern the whole frame; mid-frame input changes are ignored.
- `btc` increments every cycle in non-IDLE states. A tick occurs when `btc` = target-1, and `btc` then returns to 0. Target is `k>>1` in START and `k` in all other states.
- START tick: if `rxs`=1, it is a false start; return to IDLE with no status change. Otherwise go to DATA.
- DATA tick: shift `rxs` into data bit [index] and increment index. After bit 7 (or bit 6 if `eight`=0), go to PAR if `pen`=1, else STOP.
- PAR tick: capture the parity bit. Expected value is XOR of the received data bits, inverted when `ohel`=1. `perr_next` = captured != expected. `perr_next` = 0 when `pen`=0.
- STOP tick:
  - Load `rx_data`, `perr` and `ferr` (`ferr` = ~`rxs`).
  - Set `rxrdy`. If `rxrdy` was already 1 and `clr_rxrdy` is not asserted this cycle, set `ovf`.
  - Return to IDLE.
- Start detection is edge-based. A line held low (break) after a framing error produces no further frames until `rxs` returns high.
- `clr_rxrdy` clears `rxrdy` and `ovf`. `rx_data`, `perr` and `ferr` hold until the next STOP tick.
- Simultaneous `clr_rxrdy` and STOP tick: the completion wins (`rxrdy`=1) and `ovf`=0.

## Timing
- Reset (async, any state, including mid-frame): FSM goes to IDLE; `btc`, index and shift register are cleared; `rx_data`=8'h00; `rxrdy`, `perr`, `ferr`, `ovf`=0; synchronizer flops are set to 1.
- Synchronizer latency: 2 cycles from a `rx` change to `rxs`.
- Start sample: `k>>1` cycles after the IDLE cycle that saw the edge. Each later sample follows at `k`-cycle spacing.
- Outputs update on the clock edge ending the STOP tick cycle, so `rxrdy` is visible one cycle after the stop sample.
- Frame duration from edge detection to `rxrdy`: `k>>1` + `k`×(data bits + `pen` + 1) cycles, ±1.
- The next frame's start edge is detectable in the first IDLE cycle after STOP. This supports back-to-back frames with zero idle time.

## Test plan
- Valid 8E frame: `k`=16, `eight`=1, `pen`=1, `ohel`=0; send 0xA5 with parity 0 and stop 1. Expect `rx_data`=0xA5, `rxrdy`=1, `perr`=0, `ferr`=0, `ovf`=0.
- 7O parity error: `eight`=0, `pen`=1, `ohel`=1; send 0x41 with parity 0. Expect `rx_data`=0x41, `perr`=1 (expected parity is 1), `ferr`=0.
- Framing error: 8N1 (`pen`=0), send 0x3C with stop bit 0. Expect `rx_data`=0x3C, `ferr`=1, `perr`=0. Hold the line low afterwards and expect no second `rxrdy`.
- False start: `k`=16, pulse `rx` low for 4 cycles. Expect the FSM back in IDLE with no `rxrdy`. A proper 0x55 frame sent afterwards is received correctly.
- Overrun and clear collision: send 0x11 then 0x22 back-to-back with no `clr_rxrdy`. Expect `rx_data`=0x22 and `ovf`=1. Pulse `clr_rxrdy`: `rxrdy` and `ovf` go to 0. Repeat with `clr_rxrdy` on the STOP-tick cycle: expect `rxrdy`=1, `ovf`=0.
- Reset mid-frame: assert `reset` during DATA bit 3. All outputs go to 0 immediately. After release, a full 0x96 8N1 frame is received correctly.
